stage_if_fetch: RTL and testbench
=================================

Name: stage_if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and drives an instruction-memory request/acknowledge interface with variable latency.
- Feeds the ID stage through instr, pc_fromIF, pc4_fromIF and flush_ID; a bubble is signalled by flush_ID=1.
- Honours pipeline stalls from hazard logic and branch/jump redirects from EX.
- Allows one outstanding memory request at a time. Discards stale responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, word presented to ID during bubbles (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- stall_IF  in  1  hazard stall; hold all outputs to ID.
- br_taken  in  1  redirect request from EX.
- br_target  in  32  redirect address.
- im_req  out  1  memory request valid.
- im_addr  out  32  memory word address.
- im_ack  in  1  response valid; single-cycle pulse.
- im_rdata  in  32  instruction word; valid when im_ack=1.
- instr  out  32  instruction to ID.
- pc_fromIF  out  32  PC of instr.
- pc4_fromIF  out  32  pc_fromIF+4.
- flush_ID  out  1  1 = instr is a bubble and ID must squash it.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_reg=RESET_PC; state=IDLE; im_req=0.
  - instr=NOP_INSTR; pc_fromIF=0; pc4_fromIF=0; flush_ID=1.
  - Saved target and hold buffer are cleared.
  - Reset asserted mid-request abandons the request. A late im_ack after reset release, arriving before the first im_req, is ignored.
- States and transitions:
  - IDLE: im_req=0 → REQ on the next edge.
  - REQ: im_req=1, im_addr=pc_reg. im_req and im_addr stay stable until im_ack.
  - HOLD: a word was fetched while stalled. im_req=0; the word sits in the buffer.
  - DROP: a redirect arrived while a request was outstanding. im_req stays 1 at the old address until im_ack; the data is discarded.
- REQ, im_ack=1, no br_taken, stall_IF=0:
  - Next edge: instr=im_rdata, pc_fromIF=pc_reg, pc4_fromIF=pc_reg+4, flush_ID=0.
  - pc_reg advances by 4; state stays REQ and the next address is requested in the following cycle.
  - Fetch-to-ID latency is 1 edge after im_ack.
- REQ, im_ack=1, stall_IF=1: capture {im_rdata, pc_reg} into the buffer → HOLD. Outputs to ID are unchanged.
- HOLD, stall_IF=0: present the buffer to ID with flush_ID=0, pc_reg advances by 4 → REQ.
- REQ, im_ack=0, stall_IF=0: next edge flush_ID=1, instr=NOP_INSTR. PC outputs are don't-care but driven to 0.
- stall_IF=1 with no redirect: instr, pc_fromIF, pc4_fromIF and flush_ID all hold their values.
- Redirect (br_taken=1) has priority over stall_IF and im_ack. Next edge flush_ID=1 and instr=NOP_INSTR.
  - Target is target={br_target[31:2],2'b00}; misaligned bits are dropped.
  - In REQ with im_ack=1: discard the data, pc_reg=target, stay REQ (new im_addr appears next cycle).
  - In REQ with im_ack=0: save target → DROP.
  - In DROP: a new br_taken overwrites the saved target. On im_ack, pc_reg=saved target → REQ.
  - In HOLD: discard the buffer, pc_reg=target → REQ.
  - In IDLE: pc_reg=target → REQ.
- Arithmetic: all PC math is 32-bit modulo, so 32'hFFFF_FFFC+4 = 32'h0000_0000 and no flag is raised.
- im_ack while im_req=0 (IDLE or HOLD) is a protocol violation. It is ignored and covered by an assertion.

Decomposition:
- Package if_pkg holds:
  - the fetch state enum {IDLE, REQ, HOLD, DROP};
  - the NOP_INSTR default constant;
  - the PC increment constant 32'd4.
- Sub-module if_hold_buf: a one-entry {instr, pc} capture register with load/clear. Everything else stays in the top.

Test Plan:
- Reset release, memory acks 1 cycle after each req with 32'h00500093 at 0x0: im_addr=0x0 then 0x4. ID sees instr=32'h00500093, pc_fromIF=0, pc4_fromIF=4, flush_ID=0. Before that, flush_ID=1.
- Memory latency 3 cycles: flush_ID=1 with instr=NOP_INSTR for each wait cycle. im_addr stays stable at 0x8 until ack.
- stall_IF=1 on the ack cycle for 2 cycles: outputs hold the previous instr. On release, the buffered word at 0xC appears with flush_ID=0 and the next im_addr=0x10.
- br_taken with br_target=0x103 while a request to 0x14 is outstanding: enter DROP and discard the 0x14 data. Next im_addr=0x100. flush_ID=1 until the 0x100 word is delivered.
- br_taken coincident with stall_IF=1 and im_ack=1: the data is discarded, flush_ID=1, and im_addr=target next cycle.
- pc_reg=0xFFFF_FFFC with ack: pc4_fromIF=0x0 and the next im_addr=0x0. Assert rst mid-request: im_req=0 immediately and the outputs take their reset values.

Source files
------------

// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    // Fetch controller states, two-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // One captured instruction together with the PC it was fetched from
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } hold_entry_t;

    // addi x0,x0,0 - presented to ID whenever the stage emits a bubble
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    // Sequential instruction stride in bytes
    localparam logic [31:0] c_pc_inc = 32'd4;

endpackage : if_pkg
`default_nettype wire

// File: rtl/if_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module      : if_hold_buf
//  Description : One-entry {instr, pc} capture register. Parks a fetched word
//                that arrived while ID was stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_hold_buf
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    hold_entry_t r_entry;

    // Capture on load; clear wipes the entry so stale words never leak out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_entry <= '0;
        end else if (load) begin
            r_entry.instr <= instr_in;
            r_entry.pc    <= pc_in;
        end else if (clear) begin
            r_entry <= '0;
        end
    end

    assign instr_out = r_entry.instr;
    assign pc_out    = r_entry.pc;

endmodule : if_hold_buf
`default_nettype wire

// File: rtl/stage_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : stage_if_fetch
//  Description : Instruction-fetch stage. Owns the PC, runs a one-outstanding
//                request/ack memory interface, honours stalls and redirects,
//                and feeds ID with an instruction or a flushed bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = c_nop_instr
)(
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        stall_IF,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_fromIF,
    output logic [31:0] pc4_fromIF,
    output logic        flush_ID
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_saved_target;
    logic [31:0] w_saved_target_nxt;

    logic [31:0] r_instr;
    logic [31:0] r_pc_id;
    logic [31:0] r_pc4_id;
    logic        r_flush;

    logic [31:0] w_target;
    logic        w_deliver_mem;
    logic        w_deliver_buf;
    logic        w_bubble;
    logic        w_buf_load;
    logic        w_buf_clear;
    logic [31:0] w_buf_instr;
    logic [31:0] w_buf_pc;

    // Word-align the redirect address by masking the two low bits
    assign w_target = br_target & ~32'd3;

    // Decode of what happens to the ID-facing registers this cycle
    always_comb begin
        w_deliver_mem = (r_state == REQ)  && im_ack && !br_taken && !stall_IF;
        w_deliver_buf = (r_state == HOLD) && !br_taken && !stall_IF;
        w_buf_load    = (r_state == REQ)  && im_ack && !br_taken && stall_IF;
        w_buf_clear   = (r_state == HOLD) && (br_taken || !stall_IF);
        w_bubble      = br_taken || (!stall_IF && !w_deliver_mem && !w_deliver_buf);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a redirect without ack must wait out the old request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (br_taken && !im_ack)
                    w_state_nxt = DROP;
                else if (!br_taken && im_ack && stall_IF)
                    w_state_nxt = HOLD;
                else
                    w_state_nxt = REQ;
            end
            HOLD: begin
                if (br_taken || !stall_IF)
                    w_state_nxt = REQ;
            end
            DROP: begin
                if (im_ack)
                    w_state_nxt = REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory interface outputs; address is the live PC while requesting
    always_comb begin
        im_req  = (r_state == REQ) || (r_state == DROP);
        im_addr = r_pc;
    end

    // Next PC and saved redirect target
    always_comb begin
        w_pc_nxt           = r_pc;
        w_saved_target_nxt = r_saved_target;
        case (r_state)
            IDLE: begin
                if (br_taken)
                    w_pc_nxt = w_target;
            end
            REQ: begin
                if (br_taken && im_ack)
                    w_pc_nxt = w_target;
                else if (br_taken)
                    w_saved_target_nxt = w_target;
                else if (w_deliver_mem)
                    w_pc_nxt = r_pc + c_pc_inc;
            end
            HOLD: begin
                if (br_taken)
                    w_pc_nxt = w_target;
                else if (!stall_IF)
                    w_pc_nxt = r_pc + c_pc_inc;
            end
            DROP: begin
                if (br_taken)
                    w_saved_target_nxt = w_target;
                if (im_ack)
                    w_pc_nxt = br_taken ? w_target : r_saved_target;
            end
            default: w_pc_nxt = r_pc;
        endcase
    end

    // PC and saved-target registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc           <= RESET_PC;
            r_saved_target <= '0;
        end else begin
            r_pc           <= w_pc_nxt;
            r_saved_target <= w_saved_target_nxt;
        end
    end

    if_hold_buf u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (w_buf_load),
        .clear     (w_buf_clear),
        .instr_in  (im_rdata),
        .pc_in     (r_pc),
        .instr_out (w_buf_instr),
        .pc_out    (w_buf_pc)
    );

    // ID-facing registers: deliver, bubble, or hold while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr  <= NOP_INSTR;
            r_pc_id  <= '0;
            r_pc4_id <= '0;
            r_flush  <= 1'b1;
        end else if (w_bubble) begin
            r_instr  <= NOP_INSTR;
            r_pc_id  <= '0;
            r_pc4_id <= '0;
            r_flush  <= 1'b1;
        end else if (w_deliver_mem) begin
            r_instr  <= im_rdata;
            r_pc_id  <= r_pc;
            r_pc4_id <= r_pc + c_pc_inc;
            r_flush  <= 1'b0;
        end else if (w_deliver_buf) begin
            r_instr  <= w_buf_instr;
            r_pc_id  <= w_buf_pc;
            r_pc4_id <= w_buf_pc + c_pc_inc;
            r_flush  <= 1'b0;
        end
    end

    assign instr      = r_instr;
    assign pc_fromIF  = r_pc_id;
    assign pc4_fromIF = r_pc4_id;
    assign flush_ID   = r_flush;

    // A response with no request outstanding is a memory protocol violation
    a_ack_needs_req : assert property (@(posedge clk) disable iff (!rst) (im_ack |-> im_req))
        else $error("im_ack asserted while im_req is low");

endmodule : stage_if_fetch
`default_nettype wire

// File: tb/tb_stage_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_if_fetch
//  Description : Self-checking bench for stage_if_fetch. A small memory model
//                answers requests after a programmable latency; delivered
//                words are queued and compared when ID should see them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } id_item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_IF = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack = 1'b0;
    logic [31:0] im_rdata = '0;
    logic [31:0] instr;
    logic [31:0] pc_fromIF;
    logic [31:0] pc4_fromIF;
    logic        flush_ID;

    int checks   = 0;
    int failures = 0;

    // Memory model and scoreboard state
    int          lat      = 1;
    int          mem_cnt  = 0;
    logic        discard  = 1'b0;
    logic        delivered = 1'b0;
    id_item_t    exp_q[$];
    logic [31:0] exp_instr = NOP;
    logic [31:0] exp_pc    = '0;
    logic [31:0] exp_pc4   = '0;
    logic        exp_flush = 1'b1;

    stage_if_fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_IF   (stall_IF),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ack     (im_ack),
        .im_rdata   (im_rdata),
        .instr      (instr),
        .pc_fromIF  (pc_fromIF),
        .pc4_fromIF (pc4_fromIF),
        .flush_ID   (flush_ID)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0], 16'h0113} ^ {a[31:16], 16'h0};
    endfunction

    // One clock: memory answers, controls applied, scoreboard updated, ID checked
    task automatic tick(input logic s, input logic b, input logic [31:0] t, input string name);
        id_item_t it;
        @(negedge clk);
        if (im_req && mem_cnt >= lat) begin
            im_ack   = 1'b1;
            im_rdata = mem_word(im_addr);
            mem_cnt  = 0;
        end else begin
            im_ack   = 1'b0;
            im_rdata = 32'hDEAD_BEEF;
            if (im_req) mem_cnt++;
        end
        stall_IF  = s;
        br_taken  = b;
        br_target = t;
        delivered = 1'b0;
        if (b) begin
            exp_q.delete();
            discard   = im_req && !im_ack;
            exp_instr = NOP; exp_pc = '0; exp_pc4 = '0; exp_flush = 1'b1;
        end else begin
            if (im_ack) begin
                if (discard) discard = 1'b0;
                else begin
                    it.instr = im_rdata;
                    it.pc    = im_addr;
                    exp_q.push_back(it);
                end
            end
            if (!s) begin
                if (exp_q.size() > 0) begin
                    it = exp_q.pop_front();
                    exp_instr = it.instr; exp_pc = it.pc; exp_pc4 = it.pc + 32'd4; exp_flush = 1'b0;
                    delivered = 1'b1;
                end else begin
                    exp_instr = NOP; exp_pc = '0; exp_pc4 = '0; exp_flush = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({instr, pc_fromIF, pc4_fromIF, flush_ID} !== {exp_instr, exp_pc, exp_pc4, exp_flush}) begin
            failures++;
            $display("FAIL %s: got instr=%h pc=%h pc4=%h flush=%b, want instr=%h pc=%h pc4=%h flush=%b",
                     name, instr, pc_fromIF, pc4_fromIF, flush_ID, exp_instr, exp_pc, exp_pc4, exp_flush);
        end
        im_ack   = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic check_addr(input logic [31:0] want, input string name);
        checks++;
        if ({im_req, im_addr} !== {1'b1, want}) begin
            failures++;
            $display("FAIL %s: got im_req=%b im_addr=%h, want im_req=1 im_addr=%h", name, im_req, im_addr, want);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({im_req, instr, pc_fromIF, pc4_fromIF, flush_ID} !== {1'b0, NOP, 32'h0, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL %s: got im_req=%b instr=%h pc=%h pc4=%h flush=%b, want 0/%h/0/0/1",
                     name, im_req, instr, pc_fromIF, pc4_fromIF, flush_ID, NOP);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        mem_cnt = 0; discard = 1'b0; im_ack = 1'b0;
        stall_IF = 1'b0; br_taken = 1'b0;
        exp_instr = NOP; exp_pc = '0; exp_pc4 = '0; exp_flush = 1'b1;
    endtask

    task automatic release_and_check_first(input string name);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_addr(32'h0, name);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        release_and_check_first("first_addr");
    endtask

    task automatic test_first_fetch();
        lat = 1;
        tick(1'b0, 1'b0, 32'h0, "wait_word0");
        tick(1'b0, 1'b0, 32'h0, "deliver_word0");
        check_addr(32'h4, "addr_after_0");
        tick(1'b0, 1'b0, 32'h0, "wait_word4");
        tick(1'b0, 1'b0, 32'h0, "deliver_word4");
    endtask

    task automatic test_latency();
        int n = 0;
        lat = 3;
        while (!(im_req && mem_cnt >= lat) && n < 10) begin
            check_addr(32'h8, "addr_stable_8");
            tick(1'b0, 1'b0, 32'h0, "latency_bubble");
            n++;
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL latency_waits: got %0d wait cycles, want 3", n);
        end
        tick(1'b0, 1'b0, 32'h0, "deliver_word8");
        lat = 1;
    endtask

    task automatic test_stall();
        tick(1'b0, 1'b0, 32'h0, "wait_wordC");
        tick(1'b1, 1'b0, 32'h0, "stall_ack_hold");
        tick(1'b1, 1'b0, 32'h0, "stall_hold2");
        tick(1'b0, 1'b0, 32'h0, "release_wordC");
        check_addr(32'h10, "addr_after_hold");
    endtask

    task automatic test_redirect_drop();
        tick(1'b0, 1'b0, 32'h0, "wait_word10");
        tick(1'b0, 1'b0, 32'h0, "deliver_word10");
        check_addr(32'h14, "addr_14_outstanding");
        tick(1'b0, 1'b1, 32'h0000_0103, "redirect_bubble");
        check_addr(32'h14, "drop_keeps_addr");
        tick(1'b0, 1'b0, 32'h0, "drop_stale_ack");
        check_addr(32'h100, "addr_redirected");
        tick(1'b0, 1'b0, 32'h0, "wait_word100");
        tick(1'b0, 1'b0, 32'h0, "deliver_word100");
    endtask

    task automatic test_br_stall_ack();
        tick(1'b0, 1'b0, 32'h0, "wait_word104");
        tick(1'b1, 1'b1, 32'h0000_0200, "br_stall_ack");
        check_addr(32'h200, "addr_200");
        tick(1'b0, 1'b0, 32'h0, "wait_word200");
        tick(1'b0, 1'b0, 32'h0, "deliver_word200");
    endtask

    task automatic test_wrap();
        int n = 0;
        tick(1'b0, 1'b1, 32'hFFFF_FFFF, "wrap_redirect");
        tick(1'b0, 1'b0, 32'h0, "wrap_stale_ack");
        check_addr(32'hFFFF_FFFC, "addr_top");
        delivered = 1'b0;
        while (!delivered && n < 8) begin
            tick(1'b0, 1'b0, 32'h0, "wrap_fetch");
            n++;
        end
        checks++;
        if (!delivered) begin
            failures++;
            $display("FAIL wrap_timeout: got no delivery in %0d cycles, want one", n);
        end
        check_addr(32'h0, "addr_wrapped");
    endtask

    task automatic test_reset_mid_request();
        @(negedge clk);
        im_ack = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid_request");
        clear_model();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_held");
        release_and_check_first("restart_addr");
        tick(1'b0, 1'b0, 32'h0, "restart_wait");
        tick(1'b0, 1'b0, 32'h0, "restart_deliver");
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_latency();
        test_stall();
        test_redirect_drop();
        test_br_stall_ack();
        test_wrap();
        test_reset_mid_request();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stage_if_fetch
`default_nettype wire
